// File: rtl/imem_boot_ctrl.sv
// Boot sequencer for the instruction memory: streams a loader program into IMEM,
// releases the core with a PC clear, then halts it on the end-of-program self-loop.
module imem_boot_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter int          FETCH_LIMIT = 128,
    parameter logic [31:0] HALT_INSTR  = 32'h00000063
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              run_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    output logic              cpu_stall,
    output logic              cpu_pc_clr,
    output logic              halted,
    output logic              load_err,
    output logic              over_limit,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       cycle_count
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(FETCH_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        START,
        RUN,
        HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        det_valid;
    logic [31:0] det_pc;

    logic parked;
    logic in_range;
    logic wr_en;
    logic overflow;
    logic halt_hit;

    // word_count's top bit set means the full 2^ADDR_W words have been written
    assign parked   = (state == IDLE) || (state == HALT);
    assign in_range = !word_count[ADDR_W];
    assign wr_en    = (state == LOAD) && ld_valid && in_range;
    assign overflow = (state == LOAD) && ld_valid && !in_range;
    assign halt_hit = (state == RUN) && (instr == HALT_INSTR) && det_valid && (det_pc == pc);

    assign ld_ready   = (state == LOAD) || (state == DRAIN);
    assign mem_we     = wr_en;
    assign mem_waddr  = wr_en ? word_count[ADDR_W-1:0] : '0;
    assign mem_wdata  = wr_en ? ld_data : '0;
    assign cpu_stall  = (state != RUN);
    assign cpu_pc_clr = (state == START);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: begin
                if (load_req) begin
                    state_nxt = LOAD;
                end else if (run_req) begin
                    state_nxt = START;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    if (ld_last) begin
                        state_nxt = (overflow || load_err) ? IDLE : START;
                    end else if (overflow) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ld_valid && ld_last) begin
                    state_nxt = IDLE;
                end
            end
            START:   state_nxt = RUN;
            RUN: begin
                if (halt_hit) begin
                    state_nxt = HALT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Load bookkeeping: a new load wipes the previous load's count and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
            load_err   <= 1'b0;
            over_limit <= 1'b0;
        end else if (parked && load_req) begin
            word_count <= '0;
            load_err   <= 1'b0;
            over_limit <= 1'b0;
        end else begin
            if (wr_en) begin
                word_count <= word_count + (ADDR_W+1)'(1);
                if (word_count >= LIMIT) begin
                    over_limit <= 1'b1;
                end
            end
            if (overflow) begin
                load_err <= 1'b1;
            end
        end
    end

    // Halt needs the same pc seen twice with HALT_INSTR, so a passing fetch never halts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            det_valid   <= 1'b0;
            det_pc      <= '0;
            halted      <= 1'b0;
        end else begin
            if (parked && load_req) begin
                halted <= 1'b0;
            end else if (halt_hit) begin
                halted <= 1'b1;
            end
            if (state == START) begin
                cycle_count <= '0;
                det_valid   <= 1'b0;
                det_pc      <= '0;
            end else if (state == RUN) begin
                if (cycle_count != 32'hFFFF_FFFF) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                det_valid <= (instr == HALT_INSTR);
                det_pc    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed test-plan scenarios plus randomized
// loads and runs, compared every cycle against a behavioural model of the controller.
module tb_imem_boot_ctrl;

    localparam logic [31:0] HALT = 32'h00000063;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_req = 1'b0;
    logic        run_req = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        cpu_stall;
    logic        cpu_pc_clr;
    logic        halted;
    logic        load_err;
    logic        over_limit;
    logic [8:0]  word_count;
    logic [31:0] cycle_count;

    int checks = 0;
    int failures = 0;
    int writes_seen = 0;
    bit cmp_en = 1'b0;

    logic [31:0] prog [256];
    logic [31:0] load_q [$];

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .run_req(run_req),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .pc(pc), .instr(instr), .cpu_stall(cpu_stall), .cpu_pc_clr(cpu_pc_clr),
        .halted(halted), .load_err(load_err), .over_limit(over_limit),
        .word_count(word_count), .cycle_count(cycle_count)
    );

    // Behavioural model: activity flags instead of a state code, counts as plain integers
    bit          m_loading = 0, m_dropping = 0, m_pulse = 0, m_running = 0;
    bit          m_halted = 0, m_err = 0, m_over = 0;
    int          m_count = 0;
    longint      m_cycles = 0;
    bit          m_hist_valid = 0;
    logic [31:0] m_hist_pc = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading <= 0; m_dropping <= 0; m_pulse <= 0; m_running <= 0;
            m_halted <= 0; m_err <= 0; m_over <= 0; m_count <= 0; m_cycles <= 0;
            m_hist_valid <= 0; m_hist_pc <= '0;
        end else begin
            if (!m_loading && !m_dropping && !m_pulse && !m_running) begin
                if (load_req) begin
                    m_loading <= 1; m_count <= 0; m_err <= 0; m_over <= 0; m_halted <= 0;
                end else if (run_req) begin
                    m_pulse <= 1;
                end
            end
            if (m_loading && ld_valid) begin
                if (m_count < 256) begin
                    m_count <= m_count + 1;
                    if (m_count >= 128) m_over <= 1;
                end else begin
                    m_err <= 1;
                end
                if (ld_last) begin
                    m_loading <= 0;
                    if (m_count < 256) m_pulse <= 1;
                end else if (m_count >= 256) begin
                    m_loading <= 0;
                    m_dropping <= 1;
                end
            end
            if (m_dropping && ld_valid && ld_last) m_dropping <= 0;
            if (m_pulse) begin
                m_pulse <= 0; m_running <= 1; m_cycles <= 0; m_hist_valid <= 0;
            end
            if (m_running) begin
                m_cycles <= (m_cycles < 64'hFFFF_FFFF) ? m_cycles + 1 : m_cycles;
                if (instr == HALT && m_hist_valid && m_hist_pc == pc) begin
                    m_running <= 0;
                    m_halted <= 1;
                end
                m_hist_valid <= (instr == HALT);
                m_hist_pc <= pc;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit exp_we;
        if (cmp_en) begin
            exp_we = m_loading && ld_valid && (m_count < 256);
            checkOutput("ld_ready", ld_ready, m_loading || m_dropping);
            checkOutput("mem_we", mem_we, exp_we);
            checkOutput("mem_waddr", mem_waddr, exp_we ? 64'(m_count % 256) : 64'd0);
            checkOutput("mem_wdata", mem_wdata, exp_we ? 64'(ld_data) : 64'd0);
            checkOutput("cpu_stall", cpu_stall, !m_running);
            checkOutput("cpu_pc_clr", cpu_pc_clr, m_pulse);
            checkOutput("halted", halted, m_halted);
            checkOutput("load_err", load_err, m_err);
            checkOutput("over_limit", over_limit, m_over);
            checkOutput("word_count", word_count, 64'(m_count));
            checkOutput("cycle_count", cycle_count, 64'(m_cycles));
            if (mem_we === 1'b1) writes_seen++;
        end
    end

    function automatic logic [31:0] fetch(input logic [31:0] p);
        logic [7:0] idx;
        idx = p[9:2];
        return (idx >= 8'd128) ? HALT : prog[idx];
    endfunction

    task automatic applyStimulus(input bit lreq, input bit rreq, input bit v,
                                 input logic [31:0] d, input bit last,
                                 input logic [31:0] p, input logic [31:0] ins);
        @(posedge clk);
        #1;
        load_req = lreq; run_req = rreq; ld_valid = v; ld_data = d; ld_last = last;
        pc = p; instr = ins;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, '0, 0, '0, '0);
    endtask

    task automatic runStep(input logic [31:0] p);
        applyStimulus(0, 0, 0, '0, 0, p, fetch(p));
    endtask

    // Requests a load and streams load_q; the final word is consumed by the next call
    task automatic loadProgram(input int gap_pct);
        int i;
        applyStimulus(1, 1'($urandom_range(0, 1)), 0, '0, 0, '0, '0);
        i = 0;
        while (i < load_q.size()) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                              $urandom, 1'($urandom_range(0, 1)), '0, '0);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1,
                              load_q[i], (i == load_q.size() - 1), '0, '0);
                if (i < 256) prog[i] = load_q[i];
                i++;
            end
        end
    endtask

    task automatic fillRandom(input int len);
        load_q.delete();
        for (int i = 0; i < len; i++) begin
            load_q.push_back(($urandom_range(0, 7) == 0) ? HALT : $urandom);
        end
    endtask

    task automatic runPhase(input int max_cycles);
        logic [31:0] p;
        int r;
        p = '0;
        for (int k = 0; k < max_cycles && m_running; k++) begin
            runStep(p);
            r = $urandom_range(0, 99);
            if (r < 70) p = (p + 32'd4) & 32'h3FC;
            else if (r >= 85) p = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
        end
    endtask

    // Fetches beyond the fetch limit read HALT_INSTR, so holding pc there must halt
    task automatic forceHalt(input string name);
        for (int k = 0; k < 6 && (m_running || m_pulse); k++) runStep(32'h200);
        #1;
        checkOutput(name, {halted, cpu_stall}, 2'b11);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) prog[i] = 32'h00000013;

        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        checkOutput("reset_stall", cpu_stall, 1);
        checkOutput("reset_ready", ld_ready, 0);
        checkOutput("reset_pc_clr", cpu_pc_clr, 0);
        checkOutput("reset_count", word_count, 0);
        checkOutput("reset_cycles", cycle_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Four-word program, then run and halt on the pc=8 self-loop
        load_q = '{32'h00500093, 32'h00108113, 32'h00000063, 32'h00000013};
        w0 = writes_seen;
        loadProgram(0);
        idle();
        #2;
        checkOutput("t1_pc_clr", cpu_pc_clr, 1);
        checkOutput("t1_stall_start", cpu_stall, 1);
        checkOutput("t1_word_count", word_count, 4);
        checkOutput("t1_model_count", m_count, 4);
        checkOutput("t1_writes", writes_seen - w0, 4);
        runStep(32'h0);
        #2;
        checkOutput("t1_run_stall", cpu_stall, 0);
        checkOutput("t1_run_cycles", cycle_count, 0);
        runStep(32'h8);
        runStep(32'h8);
        idle();
        #2;
        checkOutput("t2_halted", halted, 1);
        checkOutput("t2_stall", cpu_stall, 1);
        checkOutput("t2_cycles", cycle_count, 3);
        checkOutput("t2_model_cycles", m_cycles, 3);
        idle();
        #2;
        checkOutput("t2_cycles_frozen", cycle_count, 3);

        // HALT_INSTR at changing pc must not halt; a repeat at the same pc does
        load_q = '{32'h00000013, 32'h00000013, 32'h00000063, 32'h00000063};
        loadProgram(0);
        runStep(32'h0);
        runStep(32'h8);
        runStep(32'hC);
        runStep(32'hC);
        #2;
        checkOutput("t3_no_halt", {halted, cpu_stall}, 2'b00);
        idle();
        #2;
        checkOutput("t3_halt_repeat", halted, 1);

        // 257 words overflow the IMEM
        fillRandom(257);
        w0 = writes_seen;
        loadProgram(0);
        idle();
        #2;
        checkOutput("t4_load_err", load_err, 1);
        checkOutput("t4_word_count", word_count, 256);
        checkOutput("t4_idle_ready", ld_ready, 0);
        checkOutput("t4_writes", writes_seen - w0, 256);
        applyStimulus(0, 1, 0, '0, 0, '0, '0);
        runStep(32'h0);
        #2;
        checkOutput("t4_start", cpu_pc_clr, 1);
        runStep(32'h0);
        #2;
        checkOutput("t4_run", cpu_stall, 0);
        forceHalt("t4_halt");

        // Gapped two-word load, then a 130-word load crossing the fetch limit
        w0 = writes_seen;
        applyStimulus(1, 0, 0, '0, 0, '0, '0);
        applyStimulus(0, 0, 1, 32'hAAAA0001, 0, '0, '0);
        applyStimulus(0, 0, 0, 32'hDEADBEEF, 1, '0, '0);
        applyStimulus(0, 0, 1, 32'hAAAA0002, 1, '0, '0);
        runStep(32'h0);
        #2;
        checkOutput("t5_writes", writes_seen - w0, 2);
        checkOutput("t5_over_limit", over_limit, 0);
        checkOutput("t5_word_count", word_count, 2);
        runStep(32'h0);
        forceHalt("t5_halt");
        fillRandom(130);
        loadProgram(20);
        runStep(32'h0);
        #2;
        checkOutput("t5_over_130", over_limit, 1);
        checkOutput("t5_err_130", load_err, 0);
        checkOutput("t5_count_130", word_count, 130);
        runStep(32'h0);
        forceHalt("t5_halt_130");

        // Reset in the middle of a load
        applyStimulus(1, 0, 0, '0, 0, '0, '0);
        applyStimulus(0, 0, 1, 32'h11, 0, '0, '0);
        applyStimulus(0, 0, 1, 32'h22, 0, '0, '0);
        applyStimulus(0, 0, 1, 32'h33, 0, '0, '0);
        applyStimulus(0, 0, 1, 32'h44, 0, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_ready", ld_ready, 0);
        checkOutput("t6_mem_we", mem_we, 0);
        checkOutput("t6_stall", cpu_stall, 1);
        checkOutput("t6_count", word_count, 0);
        idle();
        rst_n = 1'b1;
        idle();
        #2;
        checkOutput("t6_idle", {ld_ready, cpu_pc_clr, word_count}, 0);

        // Randomized loads and runs
        for (int it = 0; it < 10; it++) begin
            fillRandom(($urandom_range(0, 3) == 0) ? int'($urandom_range(120, 262))
                                                   : int'($urandom_range(1, 24)));
            loadProgram(30);
            runStep(32'h0);
            if (!m_pulse) begin
                applyStimulus(0, 1, 0, '0, 0, '0, '0);
                runStep(32'h0);
            end
            runStep(32'h0);
            runPhase(50);
            forceHalt("rand_halt");
        end

        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
